// File: rtl/commit_trace_buffer.sv
// Commit-trace collector: compacts up to NUM_PORTS retired records per cycle into a
// sequence-tagged FWFT FIFO. Optional macro TRACE_FILTER_X0_EN drops plain x0 writes.
module commit_trace_buffer #(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic [NUM_PORTS-1:0]      c_valid_i,
  input  logic [32*NUM_PORTS-1:0]   c_pc_i,
  input  logic [32*NUM_PORTS-1:0]   c_instr_i,
  input  logic [32*NUM_PORTS-1:0]   c_rd_data_i,
  input  logic [32*NUM_PORTS-1:0]   c_mem_addr_i,
  input  logic [32*NUM_PORTS-1:0]   c_mem_data_i,
  input  logic [5*NUM_PORTS-1:0]    c_rd_addr_i,
  input  logic [NUM_PORTS-1:0]      c_is_load_i,
  input  logic [NUM_PORTS-1:0]      c_is_store_i,
  input  logic [NUM_PORTS-1:0]      c_is_float_i,
  input  logic [2*NUM_PORTS-1:0]    c_mem_size_i,
  input  logic [5*NUM_PORTS-1:0]    c_fflags_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [31:0]               out_seq_o,
  output logic [31:0]               out_pc_o,
  output logic [31:0]               out_instr_o,
  output logic [31:0]               out_rd_data_o,
  output logic [31:0]               out_mem_addr_o,
  output logic [31:0]               out_mem_data_o,
  output logic [4:0]                out_rd_addr_o,
  output logic                      out_is_load_o,
  output logic                      out_is_store_o,
  output logic                      out_is_float_o,
  output logic [1:0]                out_mem_size_o,
  output logic [4:0]                out_fflags_o,
  output logic [31:0]               drop_count_o,
  output logic                      overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [4:0]  rd_addr;
    logic        is_load;
    logic        is_store;
    logic        is_float;
    logic [1:0]  mem_size;
    logic [4:0]  fflags;
  } rec_t;

  rec_t           mem [DEPTH];
  rec_t           lane_rec [NUM_PORTS];
  logic [AW-1:0]  lane_slot [NUM_PORTS];
  logic [PW-1:0]  lane_off [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig;
  logic [PW-1:0]  n_elig;
  logic [PW-1:0]  wr_ptr, rd_ptr, occ, free_slots;
  logic [31:0]    seq_q;
  logic [32:0]    drop_sum;
  logic           empty, admit, drop, pop;
  rec_t           head;

  always_comb begin
    n_elig = '0;
    elig   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      lane_off[k] = n_elig;
`ifdef TRACE_FILTER_X0_EN
      elig[k] = c_valid_i[k] && !((c_rd_addr_i[5*k +: 5] == 5'd0) &&
                                  !c_is_store_i[k] && !c_is_float_i[k]);
`else
      elig[k] = c_valid_i[k];
`endif
      if (elig[k]) n_elig = n_elig + PW'(1);
      lane_slot[k]         = wr_ptr[AW-1:0] + lane_off[k][AW-1:0];
      lane_rec[k].seq      = seq_q + 32'(lane_off[k]);
      lane_rec[k].pc       = c_pc_i[32*k +: 32];
      lane_rec[k].instr    = c_instr_i[32*k +: 32];
      lane_rec[k].rd_data  = c_rd_data_i[32*k +: 32];
      lane_rec[k].mem_addr = c_mem_addr_i[32*k +: 32];
      lane_rec[k].mem_data = c_mem_data_i[32*k +: 32];
      lane_rec[k].rd_addr  = c_rd_addr_i[5*k +: 5];
      lane_rec[k].is_load  = c_is_load_i[k];
      lane_rec[k].is_store = c_is_store_i[k];
      lane_rec[k].is_float = c_is_float_i[k];
      lane_rec[k].mem_size = c_mem_size_i[2*k +: 2];
      lane_rec[k].fflags   = c_fflags_i[5*k +: 5];
    end
  end

  // Room is judged on pre-pop occupancy, so a same-cycle pop never makes space.
  assign empty      = (wr_ptr[AW] == rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign occ        = wr_ptr - rd_ptr;
  assign free_slots = PW'(DEPTH) - occ;
  assign admit      = !flush_i && (n_elig != '0) && (free_slots >= n_elig);
  assign drop       = !flush_i && (n_elig != '0) && (free_slots < n_elig);
  assign pop        = !flush_i && !empty && out_ready_i;
  assign drop_sum   = {1'b0, drop_count_o} + 33'(n_elig);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (admit) begin
      for (int k = 0; k < NUM_PORTS; k++)
        if (elig[k]) mem[lane_slot[k]] <= lane_rec[k];
    end
  end

  // A flushed cycle ignores its push entirely: no seq advance, no drop count.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      seq_q        <= '0;
      drop_count_o <= '0;
      overflow_o   <= 1'b0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      seq_q <= seq_q + 32'(n_elig);
      if (admit) wr_ptr <= wr_ptr + n_elig;
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (drop) begin
        drop_count_o <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        overflow_o   <= 1'b1;
      end
    end
  end

  assign head           = mem[rd_ptr[AW-1:0]];
  assign out_valid_o    = !empty;
  assign out_seq_o      = head.seq;
  assign out_pc_o       = head.pc;
  assign out_instr_o    = head.instr;
  assign out_rd_data_o  = head.rd_data;
  assign out_mem_addr_o = head.mem_addr;
  assign out_mem_data_o = head.mem_data;
  assign out_rd_addr_o  = head.rd_addr;
  assign out_is_load_o  = head.is_load;
  assign out_is_store_o = head.is_store;
  assign out_is_float_o = head.is_float;
  assign out_mem_size_o = head.mem_size;
  assign out_fflags_o   = head.fflags;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer (NUM_PORTS=2, DEPTH=16): vector table plus
// hand sequences for overflow, full-with-pop, flush and asynchronous reset.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush;
  logic [1:0]  c_valid;
  logic [63:0] c_pc, c_instr, c_rd_data, c_mem_addr, c_mem_data;
  logic [9:0]  c_rd_addr, c_fflags;
  logic [1:0]  c_is_load, c_is_store, c_is_float;
  logic [3:0]  c_mem_size;
  logic        out_valid, out_ready;
  logic [31:0] out_seq, out_pc, out_instr, out_rd_data, out_mem_addr, out_mem_data;
  logic [4:0]  out_rd_addr, out_fflags;
  logic        out_is_load, out_is_store, out_is_float;
  logic [1:0]  out_mem_size;
  logic [31:0] drop_count;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.NUM_PORTS(2), .DEPTH(16)) dut (
    .clk_i(clk), .reset_i(rst), .flush_i(flush), .c_valid_i(c_valid),
    .c_pc_i(c_pc), .c_instr_i(c_instr), .c_rd_data_i(c_rd_data),
    .c_mem_addr_i(c_mem_addr), .c_mem_data_i(c_mem_data), .c_rd_addr_i(c_rd_addr),
    .c_is_load_i(c_is_load), .c_is_store_i(c_is_store), .c_is_float_i(c_is_float),
    .c_mem_size_i(c_mem_size), .c_fflags_i(c_fflags),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_seq_o(out_seq),
    .out_pc_o(out_pc), .out_instr_o(out_instr), .out_rd_data_o(out_rd_data),
    .out_mem_addr_o(out_mem_addr), .out_mem_data_o(out_mem_data),
    .out_rd_addr_o(out_rd_addr), .out_is_load_o(out_is_load),
    .out_is_store_o(out_is_store), .out_is_float_o(out_is_float),
    .out_mem_size_o(out_mem_size), .out_fflags_o(out_fflags),
    .drop_count_o(drop_count), .overflow_o(overflow)
  );

  typedef struct {
    logic [1:0]  v;
    logic [31:0] pc0, pc1;
    logic [4:0]  rd0, rd1;
    logic        ld0;
    logic        ev;
    logic [31:0] epc, eseq;
    logic [4:0]  erd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int k, input logic [31:0] pc, input logic [4:0] rd,
                          input logic ld);
    c_pc[32*k +: 32]       = pc;
    c_instr[32*k +: 32]    = pc ^ 32'hA5A5_0000;
    c_rd_data[32*k +: 32]  = pc + 32'd1;
    c_mem_addr[32*k +: 32] = pc + 32'd2;
    c_mem_data[32*k +: 32] = pc + 32'd3;
    c_rd_addr[5*k +: 5]    = rd;
    c_is_load[k]           = ld;
    c_is_store[k]          = 1'b0;
    c_is_float[k]          = 1'b0;
    c_mem_size[2*k +: 2]   = 2'b10;
    c_fflags[5*k +: 5]     = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    c_valid = v;
    set_lane(0, pc0, 5'd1, 1'b0);
    set_lane(1, pc1, 5'd1, 1'b0);
  endtask

  logic [31:0] base;

  initial begin
    flush = 1'b0; c_valid = '0; out_ready = 1'b0;
    c_pc = '0; c_instr = '0; c_rd_data = '0; c_mem_addr = '0; c_mem_data = '0;
    c_rd_addr = '0; c_fflags = '0; c_is_load = '0; c_is_store = '0; c_is_float = '0;
    c_mem_size = '0;

    //        v      pc0          pc1          rd0   rd1   ld0   ev    epc          eseq   erd
    vecs[0] = '{2'b11, 32'h100, 32'h104, 5'd1, 5'd1, 1'b0, 1'b1, 32'h100, 32'd0, 5'd1};
    vecs[1] = '{2'b00, 32'h0,   32'h0,   5'd0, 5'd0, 1'b0, 1'b1, 32'h104, 32'd1, 5'd1};
    vecs[2] = '{2'b00, 32'h0,   32'h0,   5'd0, 5'd0, 1'b0, 1'b0, 32'h0,   32'd0, 5'd0};
    vecs[3] = '{2'b10, 32'h0,   32'h200, 5'd0, 5'd7, 1'b0, 1'b1, 32'h200, 32'd2, 5'd7};
    vecs[4] = '{2'b00, 32'h0,   32'h0,   5'd0, 5'd0, 1'b0, 1'b0, 32'h0,   32'd0, 5'd0};
`ifdef TRACE_FILTER_X0_EN
    vecs[5] = '{2'b11, 32'h300, 32'h304, 5'd0, 5'd5, 1'b1, 1'b1, 32'h304, 32'd3, 5'd5};
    vecs[6] = '{2'b00, 32'h0,   32'h0,   5'd0, 5'd0, 1'b0, 1'b0, 32'h0,   32'd0, 5'd0};
    base = 32'd4;
`else
    vecs[5] = '{2'b11, 32'h300, 32'h304, 5'd0, 5'd5, 1'b1, 1'b1, 32'h300, 32'd3, 5'd0};
    vecs[6] = '{2'b00, 32'h0,   32'h0,   5'd0, 5'd0, 1'b0, 1'b1, 32'h304, 32'd4, 5'd5};
    base = 32'd5;
`endif
    vecs[7] = '{2'b00, 32'h0,   32'h0,   5'd0, 5'd0, 1'b0, 1'b0, 32'h0,   32'd0, 5'd0};

    #12;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_pc", out_pc, 32'd0);
    chk("reset_seq", out_seq, 32'd0);
    chk("reset_drop", drop_count, 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c_valid = vecs[i].v;
      set_lane(0, vecs[i].pc0, vecs[i].rd0, vecs[i].ld0);
      set_lane(1, vecs[i].pc1, vecs[i].rd1, 1'b0);
      if (i == 0) begin
        #1;
        chk("empty_push_same_cycle_valid", 32'(out_valid), 32'd0);
      end
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_drop", i), drop_count, 32'd0);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].epc);
        chk($sformatf("vec%0d_seq", i), out_seq, vecs[i].eseq);
        chk($sformatf("vec%0d_rd", i), 32'(out_rd_addr), 32'(vecs[i].erd));
        chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].epc ^ 32'hA5A5_0000);
        chk($sformatf("vec%0d_mem_data", i), out_mem_data, vecs[i].epc + 32'd3);
        chk($sformatf("vec%0d_mem_size", i), 32'(out_mem_size), 32'd2);
      end
    end

    // Fill to 16 with the consumer stalled, then overflow.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push2(2'b11, 32'h1000 + 32'(8*i), 32'h1004 + 32'(8*i));
      step();
    end
    chk("full_hold_pc", out_pc, 32'h1000);
    chk("full_hold_seq", out_seq, base);
    chk("full_no_drop_yet", drop_count, 32'd0);
    chk("full_no_overflow_yet", 32'(overflow), 32'd0);
    push2(2'b11, 32'h1040, 32'h1044);
    step();
    chk("ovf_drop", drop_count, 32'd2);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_head_stable", out_pc, 32'h1000);

    // Full with pop: pop happens, single-lane push is judged pre-pop and dropped.
    out_ready = 1'b1;
    push2(2'b01, 32'h2000, 32'h0);
    step();
    chk("fullpop_drop", drop_count, 32'd3);
    chk("fullpop_head_pc", out_pc, 32'h1004);
    chk("fullpop_head_seq", out_seq, base + 32'd1);
    out_ready = 1'b0;
    push2(2'b01, 32'h2004, 32'h0);
    step();
    chk("after_fullpop_admit_drop", drop_count, 32'd3);
    chk("after_fullpop_head", out_pc, 32'h1004);

    c_valid = 2'b00;
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain%0d_pc", i), out_pc, 32'h1000 + 32'(4*i));
      chk($sformatf("drain%0d_seq", i), out_seq, base + 32'(i));
      step();
    end
    chk("gap_valid", 32'(out_valid), 32'd1);
    chk("gap_pc", out_pc, 32'h2004);
    chk("gap_seq", out_seq, base + 32'd19);
    step();
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Flush with occupancy 5 and a concurrent push.
    out_ready = 1'b0;
    push2(2'b11, 32'h3000, 32'h3004); step();
    push2(2'b11, 32'h3008, 32'h300C); step();
    push2(2'b01, 32'h3010, 32'h0);    step();
    chk("preflush_seq", out_seq, base + 32'd20);
    flush = 1'b1;
    push2(2'b11, 32'h3020, 32'h3024);
    step();
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_drop_kept", drop_count, 32'd3);
    chk("flush_overflow_kept", 32'(overflow), 32'd1);
    push2(2'b01, 32'h3100, 32'h0);
    step();
    chk("postflush_valid", 32'(out_valid), 32'd1);
    chk("postflush_pc", out_pc, 32'h3100);
    chk("postflush_seq", out_seq, base + 32'd25);
    c_valid = 2'b00;
    out_ready = 1'b1;
    step();
    chk("postflush_drained", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    push2(2'b01, 32'h4000, 32'h0);
    step();
    c_valid = 2'b00;
    chk("prereset_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_drop", drop_count, 32'd0);
    chk("async_reset_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push2(2'b01, 32'h4100, 32'h0);
    step();
    c_valid = 2'b00;
    chk("postreset_pc", out_pc, 32'h4100);
    chk("postreset_seq", out_seq, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
